// File: rtl/dm_cache_fsm.sv
// Direct-mapped write-back cache controller: 1024 lines x 4 words, external tag/data arrays.
// Define DM_CACHE_STATS_EN to add saturating hit_cnt / miss_cnt outputs.
module dm_cache_fsm #(
  parameter int CNT_W = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               cpu_req_valid,
  input  logic               cpu_req_rw,
  input  logic [31:0]        cpu_req_addr,
  input  logic [31:0]        cpu_req_data,
  output logic               cpu_req_ready,
  output logic               cpu_res_ready,
  output logic [31:0]        cpu_res_data,
  output logic               mem_req_valid,
  output logic               mem_req_rw,
  output logic [31:0]        mem_req_addr,
  output logic [127:0]       mem_req_data,
  input  logic               mem_data_ready,
  input  logic [127:0]       mem_data,
  output logic [9:0]         arr_index,
  output logic               data_we,
  output logic [127:0]       data_write,
  input  logic [127:0]       data_read,
  output logic               tag_we,
  output logic [19:0]        tag_write,
  input  logic [19:0]        tag_read
`ifdef DM_CACHE_STATS_EN
  ,
  output logic [CNT_W-1:0]   hit_cnt,
  output logic [CNT_W-1:0]   miss_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, COMPARE, WRITE_BACK, ALLOCATE} state_t;

  state_t      state;
  logic        req_rw;
  logic [31:2] req_addr;
  logic [31:0] req_data;
  logic [17:0] victim_tag;
  logic        refill;

  logic [17:0] req_tag;
  logic [9:0]  req_index;
  logic [1:0]  req_word;
  logic        hit;
  logic        victim_dirty;
  logic        unused_addr_bits;

  localparam int unused_cnt_w = CNT_W;

  assign req_tag          = req_addr[31:14];
  assign req_index        = req_addr[13:4];
  assign req_word         = req_addr[3:2];
  assign hit              = tag_read[19] && (tag_read[17:0] == req_tag);
  assign victim_dirty     = tag_read[19] && tag_read[18];
  assign unused_addr_bits = ^cpu_req_addr[1:0];

  assign cpu_req_ready = (state == IDLE);
  assign arr_index     = (state == IDLE) ? cpu_req_addr[13:4] : req_index;

  // Memory side is decoded from registered state only, so it drops with reset.
  always_comb begin
    mem_req_valid = 1'b0;
    mem_req_rw    = 1'b0;
    mem_req_addr  = '0;
    mem_req_data  = '0;
    case (state)
      WRITE_BACK: begin
        mem_req_valid = 1'b1;
        mem_req_rw    = 1'b1;
        mem_req_addr  = {victim_tag, req_index, 4'b0000};
        mem_req_data  = data_read;
      end
      ALLOCATE: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {req_tag, req_index, 4'b0000};
      end
      default: ;
    endcase
  end

  always_comb begin
    cpu_res_ready = 1'b0;
    cpu_res_data  = '0;
    data_we       = 1'b0;
    data_write    = '0;
    tag_we        = 1'b0;
    tag_write     = '0;
    case (state)
      COMPARE: begin
        if (hit) begin
          cpu_res_ready = 1'b1;
          if (req_rw) begin
            data_we                           = 1'b1;
            data_write                        = data_read;
            data_write[{req_word, 5'b0} +: 32] = req_data;
            tag_we                            = 1'b1;
            tag_write                         = {2'b11, req_tag};
          end else begin
            cpu_res_data = data_read[{req_word, 5'b0} +: 32];
          end
        end
      end
      ALLOCATE: begin
        if (mem_data_ready) begin
          data_we    = 1'b1;
          data_write = mem_data;
          tag_we     = 1'b1;
          tag_write  = {2'b10, req_tag};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      req_rw     <= 1'b0;
      req_addr   <= '0;
      req_data   <= '0;
      victim_tag <= '0;
      refill     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req_valid) begin
            req_rw   <= cpu_req_rw;
            req_addr <= cpu_req_addr[31:2];
            req_data <= cpu_req_data;
            refill   <= 1'b0;
            state    <= COMPARE;
          end
        end
        COMPARE: begin
          if (hit) begin
            state <= IDLE;
          end else begin
            victim_tag <= tag_read[17:0];
            state      <= victim_dirty ? WRITE_BACK : ALLOCATE;
          end
        end
        WRITE_BACK: begin
          if (mem_data_ready) state <= ALLOCATE;
        end
        ALLOCATE: begin
          if (mem_data_ready) begin
            refill <= 1'b1;
            state  <= COMPARE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DM_CACHE_STATS_EN
  // The compare that follows a refill is not a new lookup, so it is not counted.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state == COMPARE && !refill) begin
      if (hit) begin
        if (hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
      end else begin
        if (miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dm_cache_fsm.sv
// Scoreboard bench for dm_cache_fsm: line-level reference cache, array and memory models.
module tb_dm_cache_fsm;

  logic         clk, resetn;
  logic         cpu_req_valid, cpu_req_rw;
  logic [31:0]  cpu_req_addr, cpu_req_data;
  logic         cpu_req_ready, cpu_res_ready;
  logic [31:0]  cpu_res_data;
  logic         mem_req_valid, mem_req_rw;
  logic [31:0]  mem_req_addr;
  logic [127:0] mem_req_data;
  logic         mem_data_ready;
  logic [127:0] mem_data;
  logic [9:0]   arr_index;
  logic         data_we, tag_we;
  logic [127:0] data_write, data_read;
  logic [19:0]  tag_write, tag_read;
`ifdef DM_CACHE_STATS_EN
  logic [31:0]  hit_cnt, miss_cnt;
`endif

  dm_cache_fsm #(.CNT_W(32)) dut (
    .clk(clk), .resetn(resetn),
    .cpu_req_valid(cpu_req_valid), .cpu_req_rw(cpu_req_rw),
    .cpu_req_addr(cpu_req_addr), .cpu_req_data(cpu_req_data),
    .cpu_req_ready(cpu_req_ready), .cpu_res_ready(cpu_res_ready),
    .cpu_res_data(cpu_res_data),
    .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
    .mem_data_ready(mem_data_ready), .mem_data(mem_data),
    .arr_index(arr_index),
    .data_we(data_we), .data_write(data_write), .data_read(data_read),
    .tag_we(tag_we), .tag_write(tag_write), .tag_read(tag_read)
`ifdef DM_CACHE_STATS_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {logic rw; logic [31:0] data; logic hit; int acc;} exp_t;
  typedef struct {logic rw; logic [31:0] addr; logic [127:0] data;} mem_t;

  exp_t exp_q[$];
  mem_t mem_q[$];

  int n_chk = 0, n_fail = 0;
  int cyc = 0, resp_count = 0;
  int force_stall = -1;
  bit mem_auto = 0, junk_en = 1;

  // Cache arrays owned by the bench, written only through the DUT's array ports.
  logic [19:0]  tag_mem  [1024];
  logic [127:0] data_mem [1024];
  assign tag_read  = tag_mem[arr_index];
  assign data_read = data_mem[arr_index];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tag_we)  tag_mem[arr_index]  <= tag_write;
    if (data_we) data_mem[arr_index] <= data_write;
  end

  // Reference cache state and two independent views of main memory.
  logic         m_valid [1024];
  logic         m_dirty [1024];
  logic [17:0]  m_tag   [1024];
  logic [127:0] m_line  [1024];
  logic [127:0] ref_mem  [logic [31:0]];
  logic [127:0] phys_mem [logic [31:0]];
  int m_hits = 0, m_misses = 0;

  function automatic logic [127:0] line_init(input logic [31:0] a);
    return {a ^ 32'h1357_9bdf, a + 32'h0000_0100, ~a, a * 32'd3 + 32'h55};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic abort_run(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: bound expired at cycle %0d", name, cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  endtask

  task automatic model_req(input logic rw, input logic [31:0] addr, input logic [31:0] wd,
                           output logic [31:0] rd, output logic hit);
    int idx, w;
    logic [17:0] tg;
    logic [31:0] la;
    idx = int'(addr[13:4]);
    w   = int'(addr[3:2]);
    tg  = addr[31:14];
    hit = m_valid[idx] && (m_tag[idx] == tg);
    if (hit) begin
      m_hits++;
    end else begin
      m_misses++;
      if (m_valid[idx] && m_dirty[idx]) begin
        la = {m_tag[idx], addr[13:4], 4'b0000};
        ref_mem[la] = m_line[idx];
        mem_q.push_back('{1'b1, la, m_line[idx]});
      end
      la = {tg, addr[13:4], 4'b0000};
      m_line[idx]  = ref_mem.exists(la) ? ref_mem[la] : line_init(la);
      mem_q.push_back('{1'b0, la, 128'd0});
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
      m_tag[idx]   = tg;
    end
    if (rw) begin
      m_line[idx][w*32 +: 32] = wd;
      m_dirty[idx] = 1'b1;
      rd = '0;
    end else begin
      rd = m_line[idx][w*32 +: 32];
    end
  endtask

  task automatic do_req(input logic rw, input logic [31:0] addr, input logic [31:0] wd);
    logic [31:0] rd;
    logic hit;
    int start;
    for (int k = 0; k < 100 && !cpu_req_ready; k++) @(negedge clk);
    if (!cpu_req_ready) abort_run("ready_timeout");
    cpu_req_valid = 1'b1;
    cpu_req_rw    = rw;
    cpu_req_addr  = addr;
    cpu_req_data  = wd;
    model_req(rw, addr, wd, rd, hit);
    exp_q.push_back('{rw, rd, hit, cyc});
    start = resp_count;
    @(negedge clk);
    cpu_req_valid = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (resp_count != start) break;
      if (!cpu_req_ready && junk_en && $urandom_range(0, 2) == 0) begin
        cpu_req_valid = 1'b1;
        cpu_req_rw    = 1'($urandom);
        cpu_req_addr  = $urandom;
        cpu_req_data  = $urandom;
      end else begin
        cpu_req_valid = 1'b0;
      end
      @(negedge clk);
    end
    cpu_req_valid = 1'b0;
    if (resp_count == start) abort_run("resp_timeout");
  endtask

  // Response monitor.
  always @(negedge clk) begin
    exp_t e;
    if (resetn && cpu_res_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_response: got data %h, expected no response", cpu_res_data);
      end else begin
        e = exp_q.pop_front();
        chk(e.rw ? "write_res_data" : "read_res_data", 128'(cpu_res_data), 128'(e.data));
        if (e.hit) chk("hit_latency", 128'(cyc), 128'(e.acc + 1));
        else begin
          n_chk++;
          if (cyc <= e.acc + 2) begin
            n_fail++;
            $display("FAIL miss_latency: got cycle %0d expected after %0d", cyc, e.acc + 2);
          end
        end
        resp_count++;
      end
    end
    if (mem_req_valid) chk("busy_ready_low", 128'(cpu_req_ready), 128'd0);
  end

  // Memory responder with random or forced stalls.
  initial begin
    mem_t m;
    int stall;
    mem_data_ready = 1'b0;
    mem_data       = '0;
    forever begin
      @(negedge clk);
      mem_data_ready = 1'b0;
      if (mem_auto && mem_req_valid) begin
        if (mem_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_mem_req: got rw %0d addr %h, expected none", mem_req_rw, mem_req_addr);
          m = '{mem_req_rw, mem_req_addr, mem_req_data};
        end else begin
          m = mem_q.pop_front();
          chk("mem_rw", 128'(mem_req_rw), 128'(m.rw));
          chk("mem_addr", 128'(mem_req_addr), 128'(m.addr));
          if (m.rw) chk("mem_wb_data", mem_req_data, m.data);
        end
        stall = (force_stall >= 0) ? force_stall : int'($urandom_range(0, 3));
        force_stall = -1;
        for (int s = 0; s < stall; s++) begin
          @(negedge clk);
          chk("stall_valid", 128'(mem_req_valid), 128'd1);
          chk("stall_addr", 128'(mem_req_addr), 128'(m.addr));
          chk("stall_rw", 128'(mem_req_rw), 128'(m.rw));
          chk("stall_cpu_ready", 128'(cpu_req_ready), 128'd0);
        end
        if (mem_req_rw) phys_mem[mem_req_addr] = mem_req_data;
        else mem_data = phys_mem.exists(mem_req_addr) ? phys_mem[mem_req_addr] : line_init(mem_req_addr);
        mem_data_ready = 1'b1;
      end
    end
  end

  initial begin
    logic [31:0] a;
    for (int i = 0; i < 1024; i++) begin
      tag_mem[i] = '0;  data_mem[i] = '0;
      m_valid[i] = 1'b0; m_dirty[i] = 1'b0; m_tag[i] = '0; m_line[i] = '0;
    end
    resetn = 1'b0;
    cpu_req_valid = 1'b0; cpu_req_rw = 1'b0; cpu_req_addr = '0; cpu_req_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_cpu_req_ready", 128'(cpu_req_ready), 128'd1);
    chk("rst_cpu_res_ready", 128'(cpu_res_ready), 128'd0);
    chk("rst_cpu_res_data", 128'(cpu_res_data), 128'd0);
    chk("rst_mem_req", {mem_req_valid, mem_req_rw, mem_req_addr}, 128'd0);
    chk("rst_mem_req_data", mem_req_data, 128'd0);
    chk("rst_array_we", {data_we, tag_we}, 128'd0);
    resetn = 1'b1;

    // Reset in the middle of a refill: request dropped, nothing returned.
    @(negedge clk);
    cpu_req_valid = 1'b1; cpu_req_rw = 1'b0; cpu_req_addr = 32'h0000_5050;
    @(negedge clk);
    cpu_req_valid = 1'b0;
    for (int k = 0; k < 10 && !mem_req_valid; k++) @(negedge clk);
    chk("alloc_valid", 128'(mem_req_valid), 128'd1);
    chk("alloc_addr", 128'(mem_req_addr), 128'h0000_5050);
    @(negedge clk);
    #3 resetn = 1'b0;
    #1;
    chk("async_rst_mem_valid", 128'(mem_req_valid), 128'd0);
    chk("async_rst_idle", 128'(cpu_req_ready), 128'd1);
    chk("async_rst_no_res", 128'(cpu_res_ready), 128'd0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    chk("async_rst_no_tag_write", 128'(tag_mem[10'h105]), 128'd0);
    mem_auto = 1'b1;

    // Fill, write hit, dirty eviction with a long stall.
    do_req(1'b0, 32'h0000_4018, 32'h0);
    chk("fill_tag", 128'(tag_mem[1]), 128'h80001);
    do_req(1'b1, 32'h0000_4014, 32'hDEAD_BEEF);
    chk("write_tag_dirty", 128'(tag_mem[1]), 128'hC0001);
    chk("write_word1", 128'(data_mem[1][63:32]), 128'hDEAD_BEEF);
    force_stall = 5;
    do_req(1'b0, 32'h0000_8010, 32'h0);
    chk("evict_tag", 128'(tag_mem[1]), 128'h80002);
    chk("wb_line_word1", 128'(phys_mem[32'h0000_4010][63:32]), 128'hDEAD_BEEF);
`ifdef DM_CACHE_STATS_EN
    chk("stats_hit", 128'(hit_cnt), 128'd1);
    chk("stats_miss", 128'(miss_cnt), 128'd2);
`endif

    for (int i = 0; i < 150; i++) begin
      a = {14'(0), 2'($urandom_range(1, 3)), 6'd0, 2'($urandom_range(0, 3)),
           2'($urandom_range(0, 3)), 2'($urandom), 2'($urandom)};
      a[31:14] = 18'($urandom_range(1, 3));
      do_req(1'($urandom), a, $urandom);
    end

    repeat (5) @(negedge clk);
    chk("exp_q_drained", 128'(exp_q.size()), 128'd0);
    chk("mem_q_drained", 128'(mem_q.size()), 128'd0);
`ifdef DM_CACHE_STATS_EN
    chk("stats_hit_total", 128'(hit_cnt), 128'(m_hits));
    chk("stats_miss_total", 128'(miss_cnt), 128'(m_misses));
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dm_cache_fsm.md
DM_CACHE_FSM -- requirements
Module: dm_cache_fsm

Interface
REQ-001 Parameter CNT_W, default 32, width of the statistics counters (used only when DM_CACHE_STATS_EN is defined).
REQ-002 clk  in  1  single clock, all state updates on its rising edge.
REQ-003 resetn  in  1  reset, asynchronous, active-low.
REQ-004 cpu_req_valid  in  1  CPU request present.
REQ-005 cpu_req_rw  in  1  1=write, 0=read.
REQ-006 cpu_req_addr  in  32  byte address: tag [31:14], index [13:4], word [3:2], [1:0] ignored.
REQ-007 cpu_req_data  in  32  write word.
REQ-008 cpu_req_ready  out  1  block accepts a request this cycle.
REQ-009 cpu_res_ready  out  1  one-cycle completion pulse.
REQ-010 cpu_res_data  out  32  read word; valid while cpu_res_ready=1 on a read, else 0.
REQ-011 mem_req_valid  out  1  memory request present.
REQ-012 mem_req_rw  out  1  1=line write-back, 0=line fill.
REQ-013 mem_req_addr  out  32  line address, bits [3:0]=0.
REQ-014 mem_req_data  out  128  write-back line.
REQ-015 mem_data_ready  in  1  memory completes the current request this cycle.
REQ-016 mem_data  in  128  fill line, valid with mem_data_ready.
REQ-017 arr_index  out  10  index to tag and data arrays.
REQ-018 data_we / data_write / data_read  out 1 / out 128 / in 128  data-array write enable, write line, combinational read line.
REQ-019 tag_we / tag_write / tag_read  out 1 / out 20 / in 20  tag-array port, format {valid, dirty, tag[17:0]}, combinational read.

Function
REQ-020 States: IDLE, COMPARE, WRITE_BACK, ALLOCATE; encoding free.
REQ-021 cpu_req_ready = 1 only in IDLE; cpu_req_valid outside IDLE is ignored.
REQ-022 IDLE & cpu_req_valid: capture rw, addr, data into request register; next state COMPARE.
REQ-023 arr_index = captured addr[13:4] in every non-IDLE state and cpu_req_addr[13:4] in IDLE.
REQ-024 COMPARE hit (tag_read.valid & tag_read.tag == captured tag): cpu_res_ready=1 this cycle; next IDLE.
REQ-025 Read hit: cpu_res_data = data_read word selected by addr[3:2] (word 0 = bits [31:0]).
REQ-026 Write hit: data_we=1, data_write = data_read with the selected word replaced; tag_we=1, tag_write={1,1,tag}.
REQ-027 Hit latency: acceptance in cycle N, cpu_res_ready in cycle N+1.
REQ-028 COMPARE miss: capture victim tag; valid & dirty -> WRITE_BACK, else ALLOCATE; no array writes.
REQ-029 WRITE_BACK: mem_req_valid=1, rw=1, addr={victim tag, index, 4'b0}, data=data_read; on mem_data_ready next ALLOCATE.
REQ-030 ALLOCATE: mem_req_valid=1, rw=0, addr={captured tag, index, 4'b0}; on mem_data_ready: data_we=1 with mem_data, tag_we=1 with {1,0,tag}; next COMPARE.
REQ-031 mem_req_* held stable until the mem_data_ready cycle; mem_data_ready outside WRITE_BACK/ALLOCATE ignored.
REQ-032 mem_req_valid deasserts in the cycle following mem_data_ready (a state change occurs).
REQ-033 Clean miss total: COMPARE, ALLOCATE (>=1 cycle), COMPARE (hit, response).

Reset
REQ-034 resetn low: state IDLE immediately, request and victim registers cleared.
REQ-035 Reset values: cpu_req_ready=1, cpu_res_ready=0, cpu_res_data=0, mem_req_valid=0, mem_req_rw=0, mem_req_addr=0, mem_req_data=0, data_we=0, tag_we=0.
REQ-036 Reset mid-transaction drops mem_req_valid asynchronously and discards the captured request; no response.

Configuration
REQ-037 Macro DM_CACHE_STATS_EN defined: outputs hit_cnt and miss_cnt (CNT_W each, reset 0, saturating at all-ones).
REQ-038 hit_cnt increments on a first-pass COMPARE hit; miss_cnt on a COMPARE miss; a re-compare after ALLOCATE counts as neither.
REQ-039 DM_CACHE_STATS_EN undefined: ports and counters absent; all other behaviour identical.

Verification
REQ-040 Empty tags, read 0x0000_4018 -> ALLOCATE at mem_req_addr 0x0000_4010, fill returns, read response = fill word 2, tag = {1,0,0x00001}.
REQ-041 Write 0xDEADBEEF to 0x0000_4014 after REQ-040 -> response at N+1, word 1 updated, tag dirty=1.
REQ-042 Read 0x0000_8010 (same index, other tag) -> WRITE_BACK at 0x0000_4010 with dirty line, then ALLOCATE at 0x0000_8010.
REQ-043 Memory stalls mem_data_ready 5 cycles; cpu_req_valid pulsed meanwhile -> mem_req_* stable, extra request ignored, cpu_req_ready=0.
REQ-044 resetn low during ALLOCATE -> mem_req_valid=0 same cycle, state IDLE, no cpu_res_ready.
REQ-045 DM_CACHE_STATS_EN set, sequence REQ-040..042 -> hit_cnt=1, miss_cnt=2.
